// File: rtl/th2bin_pipe.sv
// Two-stage thermometer-to-binary decoder with valid/ready handshake, raw-code error flag and saturating error count.
// Latency 2 cycles; IN_READY drops only when both stages hold data and OUT_READY is low. Optional TH2BIN_BUBBLE_FIX_EN enables majority bubble correction.
module th2bin_pipe #(
   parameter int OUTWIDTH = 3,
   parameter int INWIDTH  = (1 << OUTWIDTH) - 1,
   parameter int CNTWIDTH = 8
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                IN_VALID,
   output logic                IN_READY,
   input  logic [INWIDTH-1:0]  IN,
   output logic                OUT_VALID,
   input  logic                OUT_READY,
   output logic [OUTWIDTH-1:0] OUT,
   output logic                ERR,
   input  logic                CLR,
   output logic [CNTWIDTH-1:0] ERR_CNT
);

   logic                s1v_q, s1v_d;
   logic [INWIDTH-1:0]  c_q, c_d;
   logic                e_q, e_d;
   logic                s2v_q, s2v_d;
   logic [OUTWIDTH-1:0] out_q, out_d;
   logic                err_q, err_d;
   logic [CNTWIDTH-1:0] cnt_q, cnt_d;

   logic in_xfer, out_xfer, s2_load;

   assign IN_READY = ~s1v_q | ~s2v_q | OUT_READY;
   assign in_xfer  = IN_VALID & IN_READY;
   assign out_xfer = s2v_q & OUT_READY;
   assign s2_load  = s1v_q & (~s2v_q | OUT_READY);

   // Error looks at the raw code in both builds: any 1 sitting above a 0.
   assign e_d = |(IN[INWIDTH-1:1] & ~IN[INWIDTH-2:0]);

`ifdef TH2BIN_BUBBLE_FIX_EN
   logic [INWIDTH+1:0] t_ext;
   always_comb begin
      t_ext = {1'b0, IN, 1'b1};
      c_d   = '0;
      for (int i = 0; i < INWIDTH; i++) begin
         c_d[i] = (t_ext[i] & t_ext[i+1]) | (t_ext[i] & t_ext[i+2]) | (t_ext[i+1] & t_ext[i+2]);
      end
   end
`else
   assign c_d = IN;
`endif

   always_comb begin
      out_d = '0;
      for (int i = 0; i < INWIDTH; i++) begin
         out_d = out_d + OUTWIDTH'(c_q[i]);
      end
   end

   assign err_d = e_q;
   assign s1v_d = IN_READY ? IN_VALID : s1v_q;

   always_comb begin
      s2v_d = s2v_q;
      if (s2_load) begin
         s2v_d = 1'b1;
      end else if (OUT_READY) begin
         s2v_d = 1'b0;
      end
   end

   // Clear takes priority over a coincident increment; all-ones is sticky.
   always_comb begin
      cnt_d = cnt_q;
      if (CLR) begin
         cnt_d = '0;
      end else if (out_xfer && err_q && (cnt_q != {CNTWIDTH{1'b1}})) begin
         cnt_d = cnt_q + CNTWIDTH'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1v_q <= 1'b0;
         c_q   <= '0;
         e_q   <= 1'b0;
      end else begin
         s1v_q <= s1v_d;
         if (in_xfer) begin
            c_q <= c_d;
            e_q <= e_d;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s2v_q <= 1'b0;
         out_q <= '0;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s2v_q <= s2v_d;
         cnt_q <= cnt_d;
         if (s2_load) begin
            out_q <= out_d;
            err_q <= err_d;
         end
      end
   end

   assign OUT_VALID = s2v_q;
   assign OUT       = out_q;
   assign ERR       = err_q;
   assign ERR_CNT   = cnt_q;

endmodule

// File: tb/tb_th2bin_pipe.sv
// Scoreboard bench for th2bin_pipe: driver pushes model results on input transfers, a negedge monitor pops and compares.
module tb_th2bin_pipe;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       IN_VALID;
   logic       IN_READY;
   logic [6:0] IN;
   logic       OUT_VALID;
   logic       OUT_READY;
   logic [2:0] OUT;
   logic       ERR;
   logic       CLR;
   logic [7:0] ERR_CNT;

   int total = 0;
   int bad   = 0;

   logic [3:0] sb[$];
   int         cnt_m = 0;
   logic       prev_stall = 1'b0;
   logic [2:0] prev_out;
   logic       prev_err;

   th2bin_pipe #(.OUTWIDTH(3), .INWIDTH(7), .CNTWIDTH(8)) dut (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN(IN),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT(OUT), .ERR(ERR),
      .CLR(CLR), .ERR_CNT(ERR_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [6:0] cond_code(input logic [6:0] t);
      logic [6:0] r;
`ifdef TH2BIN_BUBBLE_FIX_EN
      logic [8:0] e;
      e = {1'b0, t, 1'b1};
      for (int i = 0; i < 7; i++) begin
         r[i] = (int'(e[i]) + int'(e[i+1]) + int'(e[i+2])) >= 2;
      end
`else
      r = t;
`endif
      return r;
   endfunction

   function automatic logic [3:0] model(input logic [6:0] t);
      int v;
      int pc;
      logic is_err;
      v      = int'(t);
      is_err = (v & (v + 1)) != 0;
      pc     = $countones(cond_code(t));
      return {is_err, pc[2:0]};
   endfunction

   function automatic logic [6:0] rand_code();
      int k;
      if ($urandom % 2 == 0) begin
         k = $urandom_range(0, 7);
         return 7'((1 << k) - 1);
      end
      return 7'($urandom);
   endfunction

   function automatic logic [6:0] err_code();
      return 7'((($urandom % 32) << 2) | 2);
   endfunction

   // Monitor: inputs are stable at the falling edge, so transfers for the next rising edge are known here.
   always @(negedge CLK) begin
      logic [3:0] exp;
      if (!RST_N) begin
         sb.delete();
         cnt_m      = 0;
         prev_stall = 1'b0;
      end else begin
         check("err_cnt", ERR_CNT, cnt_m);
         check("in_ready_rule", IN_READY, !(sb.size() == 2 && !OUT_READY));
         if (sb.size() == 0) check("idle_no_valid", OUT_VALID, 0);
         if (prev_stall) begin
            check("stall_valid", OUT_VALID, 1);
            check("stall_out", OUT, prev_out);
            check("stall_err", ERR, prev_err);
         end
         exp = 4'b0;
         if (OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               exp = sb.pop_front();
               check("out_value", OUT, exp[2:0]);
               check("out_err", ERR, exp[3]);
            end
         end
         if (CLR) cnt_m = 0;
         else if (OUT_VALID && OUT_READY && exp[3] && cnt_m < 255) cnt_m++;
         if (IN_VALID && IN_READY) sb.push_back(model(IN));
         prev_stall = OUT_VALID && !OUT_READY;
         prev_out   = OUT;
         prev_err   = ERR;
      end
   end

   // rdy_mode: 0 = OUT_READY low, 1 = high, 2 = random each cycle.
   task automatic send(input logic [6:0] code, input int rdy_mode, output int tries);
      bit acc;
      acc      = 1'b0;
      tries    = 0;
      IN_VALID = 1'b1;
      IN       = code;
      while (!acc && tries < 50) begin
         OUT_READY = (rdy_mode == 2) ? 1'($urandom % 2) : (rdy_mode == 1);
         @(negedge CLK);
         acc = IN_READY;
         @(posedge CLK);
         #1;
         tries++;
      end
      IN_VALID = 1'b0;
      IN       = 7'($urandom);
      if (!acc) check("send_timeout", 0, 1);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic lat(input logic [6:0] code, input int eo, input int ee, output int tries);
      send(code, 1, tries);
      check("lat_early_valid", OUT_VALID, 0);
      cyc(1);
      check("lat_valid", OUT_VALID, 1);
      check("lat_out", OUT, eo);
      check("lat_err", ERR, ee);
      cyc(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      RST_N     = 1'b0;
      IN_VALID  = 1'b0;
      IN        = '0;
      OUT_READY = 1'b0;
      CLR       = 1'b0;
      cyc(2);
      check("rst_out_valid", OUT_VALID, 0);
      check("rst_out", OUT, 0);
      check("rst_err", ERR, 0);
      check("rst_err_cnt", ERR_CNT, 0);
      check("rst_in_ready", IN_READY, 1);
      RST_N = 1'b1;
      cyc(1);

      lat(7'b0011111, 5, 0, n);
      lat(7'b0000000, 0, 0, n);
      lat(7'b1111111, 7, 0, n);
      check("cnt_after_valid", ERR_CNT, 0);

`ifdef TH2BIN_BUBBLE_FIX_EN
      lat(7'b0001101, 4, 1, n);
`else
      lat(7'b0001101, 3, 1, n);
`endif
      check("cnt_after_bubble", ERR_CNT, 1);

      for (int i = 0; i < 8; i++) send(rand_code(), 2, n);
      OUT_READY = 1'b1;
      cyc(4);
      check("stream_drained", sb.size(), 0);

      send(rand_code(), 0, n);
      send(rand_code(), 0, n);
      IN_VALID = 1'b1;
      IN       = rand_code();
      #1;
      check("full_blocks", IN_READY, 0);
      cyc(3);
      OUT_READY = 1'b1;
      #1;
      check("release_ready", IN_READY, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check("release_out_valid", OUT_VALID, 1);
         check("release_in_ready", IN_READY, 1);
         @(posedge CLK);
         #1;
         IN = rand_code();
      end
      IN_VALID = 1'b0;
      cyc(4);
      check("release_drained", sb.size(), 0);

      for (int i = 0; i < 300; i++) send(err_code(), 1, n);
      cyc(3);
      check("cnt_saturated", ERR_CNT, 255);
      send(err_code(), 1, n);
      cyc(1);
      check("clr_setup_valid", OUT_VALID, 1);
      CLR = 1'b1;
      cyc(1);
      CLR = 1'b0;
      check("clr_wins", ERR_CNT, 0);

      send(err_code(), 1, n);
      cyc(2);
      check("pre_reset_cnt", ERR_CNT, 1);
      send(rand_code(), 0, n);
      send(rand_code(), 0, n);
      #2;
      RST_N = 1'b0;
      #1;
      check("arst_out_valid", OUT_VALID, 0);
      check("arst_err_cnt", ERR_CNT, 0);
      check("arst_in_ready", IN_READY, 1);
      check("arst_out", OUT, 0);
      @(negedge CLK);
      cyc(1);
      RST_N = 1'b1;
      lat(7'b0000111, 3, 0, n);
      check("post_reset_accept_first_edge", n, 1);

      cyc(3);
      check("final_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/th2bin_pipe.md
# th2bin_pipe

Pipelined thermometer-to-binary decoder with valid/ready flow control, the receive-side counterpart of the `bin2th` binary-to-thermometer encoder. It accepts a `(1<<OUTWIDTH)-1`-bit thermometer code and emits its binary count two cycles later. It flags codes that are not valid thermometer patterns and keeps a saturating error count. It sits behind comparator banks and DAC-control loopback paths, where thermometer codes must be converted back to binary.

## Interface
Parameters:
- `OUTWIDTH`, default 3: binary output width.
- `INWIDTH`, default `(1<<OUTWIDTH)-1`: thermometer input width. Must equal the default expression.
- `CNTWIDTH`, default 8: error counter width.

Ports:
- `CLK`, input, 1: the single clock. All logic is rising-edge triggered.
- `RST_N`, input, 1: reset, asynchronous and active-low.
- `IN_VALID`, input, 1: input code present.
- `IN_READY`, output, 1: block can take an input this cycle.
- `IN`, input, INWIDTH: thermometer code. Bit 0 is the lowest level.
- `OUT_VALID`, output, 1: result present.
- `OUT_READY`, input, 1: downstream takes the result.
- `OUT`, output, OUTWIDTH: decoded binary value.
- `ERR`, output, 1: the raw input for this result was not a thermometer code.
- `CLR`, input, 1: synchronous clear of `ERR_CNT`.
- `ERR_CNT`, output, CNTWIDTH: saturating count of erroneous results.

## Operation
- An input transfer occurs when `IN_VALID & IN_READY`. An output transfer occurs when `OUT_VALID & OUT_READY`.
- Stage 1 registers the following, valid flag S1V:
  - the conditioned code C (see Configuration);
  - the raw error flag E = OR over i of (`IN[i+1]` & ~`IN[i]`), for i = 0..INWIDTH-2.
- Stage 2 registers the following, valid flag S2V = `OUT_VALID`:
  - `OUT` = popcount(C). The maximum value INWIDTH fits in OUTWIDTH bits, so no overflow is possible.
  - `ERR` = E.
- Advance rules:
  - Stage 2 loads when S1V & (~S2V | `OUT_READY`).
  - Stage 1 loads when `IN_READY`.
  - `IN_READY` = ~S1V | ~S2V | `OUT_READY`. This is a combinational path from `OUT_READY`.
- A valid flag clears when its stage is drained with nothing new loading behind it.
- While `OUT_VALID`=1 and `OUT_READY`=0, `OUT` and `ERR` hold stable.
- Error counter `ERR_CNT`:
  - increments by 1 on each output transfer with `ERR`=1;
  - holds at all-ones once saturated;
  - `CLR`=1 forces it to 0 on the next edge;
  - if `CLR` and an increment coincide, `CLR` wins and the result is 0.
- No data is dropped or duplicated. Output order equals input order.

## Timing
- Reset values while `RST_N`=0, applied asynchronously:
  - `OUT_VALID`=0, `OUT`=0, `ERR`=0, `ERR_CNT`=0;
  - S1V=0 and C=0;
  - `IN_READY`=1, since both stages are empty.
- Latency: an input accepted at edge N appears with `OUT_VALID`=1 after edge N+1, when downstream is not stalling.
- Throughput: one transfer per cycle while `OUT_READY` stays high.
- Full pipe: with S1V=S2V=1 and `OUT_READY`=0, `IN_READY`=0.
- Full pipe releasing: with S1V=S2V=1 and `OUT_READY`=1, the output transfer and a new input transfer occur on the same edge.
- Reset asserted mid-operation: in-flight data is discarded immediately and outputs take their reset values. The first edge after `RST_N` rises accepts input normally.
- `IN` is sampled only on an input transfer. It may change freely at other times.

## Configuration
- Macro: `TH2BIN_BUBBLE_FIX_EN`.
- Defined: C[i] = majority(t[i-1], t[i], t[i+1]), where t = `IN`, with boundary values t[-1]=1 and t[INWIDTH]=0. This corrects single-bit bubbles.
- Undefined: C = `IN` unchanged.
- `ERR` is always computed from the raw `IN`, in both builds.

## Test plan
All scenarios use OUTWIDTH=3 and INWIDTH=7.
1. Reset, then `IN`=7'b0011111 with `IN_VALID`=1 and `OUT_READY`=1 → 2 cycles later `OUT`=5, `ERR`=0, `ERR_CNT`=0. Also `IN`=0 → `OUT`=0, and `IN`=7'h7F → `OUT`=7.
2. `IN`=7'b0001101:
   - macro defined → `OUT`=4, `ERR`=1;
   - macro undefined → `OUT`=3, `ERR`=1;
   - `ERR_CNT` goes to 1 in both builds.
3. Stream 8 codes back-to-back with `OUT_READY` toggling randomly → outputs match the inputs in order with none lost. `IN_READY`=0 exactly when both stages are full and `OUT_READY`=0.
4. Hold `OUT_READY`=0 after 2 inputs → `IN_READY`=0 and `OUT` stable. Raise `OUT_READY` → one output per cycle, with a simultaneous input accept.
5. Send 300 erroneous codes with CNTWIDTH=8 → `ERR_CNT` holds at 255. Then assert `CLR` on the same cycle as an erroneous output transfer → `ERR_CNT`=0.
6. Drop `RST_N` asynchronously between edges with the pipe full → `OUT_VALID`=0 and `ERR_CNT`=0 immediately, `IN_READY`=1. Release reset → the next code decodes with 2-cycle latency.
